// File: rtl/remote_comm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | remote_comm : serializes a 16-bit command as two 8N1 UART frames, MSB     |
// | byte first, with a completion flag.        Rev 1.0                        |
// +--------------------------------------------------------------------------+
module remote_comm #(
  parameter int BAUD_CYCLES = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        TX,
  output logic        cmd_sent,
  output logic        busy
);

  localparam logic [15:0] C_BAUD_LAST = 16'(BAUD_CYCLES - 1);
  localparam logic [3:0]  C_STOP_BIT  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q,  hold_d;
  logic [9:0]  shift_q, shift_d;
  logic [15:0] baud_q,  baud_d;
  logic [3:0]  bit_q,   bit_d;
  logic        sent_q,  sent_d;
  logic        busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  // The shifter's LSB is the line itself; ones shift in so an exhausted frame idles high.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (send_cmd) begin
          state_d = HIGH;
          hold_d  = cmd;
          sent_d  = 1'b0;
          shift_d = {1'b1, cmd[15:8], 1'b0};
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      HIGH, LOW: begin
        if (baud_q == C_BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == C_STOP_BIT) begin
            bit_d = '0;
            if (state_q == HIGH) begin
              state_d = LOW;
              shift_d = {1'b1, hold_q[7:0], 1'b0};
            end else begin
              state_d = IDLE;
              shift_d = '1;
              sent_d  = 1'b1;
            end
          end else begin
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign TX       = shift_q[0];
  assign cmd_sent = sent_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_remote_comm : self-checking bench for remote_comm (B = 8).             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_remote_comm;

  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        send_cmd = 1'b0;
  logic        TX;
  logic        cmd_sent;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int t;

  remote_comm #(.BAUD_CYCLES(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .TX       (TX),
    .cmd_sent (cmd_sent),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] c;
    int          inj_at;
    logic [15:0] inj;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected line level t cycles after acceptance, from the framing rules.
  function automatic logic model_tx(input logic [15:0] c, input int tt);
    int bitn, fr, k, byt;
    bitn = tt / B;
    fr   = bitn / 10;
    k    = bitn % 10;
    if (fr > 1) return 1'b1;
    byt = (fr == 0) ? (int'(c) / 256) : (int'(c) % 256);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return 1'((byt >> (k - 1)) % 2);
  endfunction

  task automatic run_cmd(input logic [15:0] c, input int inj_at, input logic [15:0] inj,
                         input logic [7:0] exp_hi, input logic [7:0] exp_lo, input string nm);
    logic [7:0] dec [2];
    int bad_tx, bad_st, bitn, k;
    bad_tx = 0;
    bad_st = 0;
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    send_cmd = 1'b0;
    cmd = 16'($urandom);
    check({nm, "_accept"}, {29'd0, TX, busy, cmd_sent}, 32'b010);
    t = 0;
    while (t < 20 * B) begin
      if (TX !== model_tx(c, t)) bad_tx++;
      if (busy !== 1'b1 || cmd_sent !== 1'b0) bad_st++;
      if (t % B == B / 2) begin
        bitn = t / B;
        k = bitn % 10;
        if (k >= 1 && k <= 8) dec[bitn / 10][k - 1] = TX;
      end
      if (t == inj_at - 1) begin
        cmd = inj;
        send_cmd = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
      send_cmd = 1'b0;
      cmd = 16'($urandom);
    end
    check({nm, "_tx_wave"}, bad_tx, 0);
    check({nm, "_busy_window"}, bad_st, 0);
    check({nm, "_byte_hi"}, {24'd0, dec[0]}, {24'd0, exp_hi});
    check({nm, "_byte_lo"}, {24'd0, dec[1]}, {24'd0, exp_lo});
    check({nm, "_done"}, {29'd0, TX, busy, cmd_sent}, 32'b101);
  endtask

  initial begin
    vec_t vecs [4];
    int bad;
    logic [15:0] rc;
    int ri;

    vecs[0] = '{16'h2000, -1, 16'h0000, 8'h20, 8'h00};
    vecs[1] = '{16'h6023, -1, 16'h0000, 8'h60, 8'h23};
    vecs[2] = '{16'h4002, 50, 16'h5FFF, 8'h40, 8'h02};
    vecs[3] = '{16'hC3A5, 160, 16'h1234, 8'hC3, 8'hA5};

    // Reset held: outputs must stay quiet while inputs toggle.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      send_cmd = 1'($urandom);
      cmd = 16'($urandom);
      if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0) bad++;
    end
    check("reset_hold", bad, 0);
    @(negedge clk);
    send_cmd = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0) bad++;
    end
    check("post_reset_idle", bad, 0);

    for (int i = 0; i < 4; i++)
      run_cmd(vecs[i].c, vecs[i].inj_at, vecs[i].inj, vecs[i].exp_hi, vecs[i].exp_lo,
              $sformatf("vec%0d", i));

    // Follows vec3 directly: its edge-160 pulse was ignored, this one lands at E0+161.
    run_cmd(16'h5A3C, -1, 16'h0000, 8'h5A, 8'h3C, "reaccept");

    // Reset in the middle of the low byte.
    @(negedge clk);
    cmd = 16'h4ABC;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    send_cmd = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midframe_pre_tx", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midframe_async", {29'd0, TX, busy, cmd_sent}, 32'b100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0) bad++;
    end
    check("midframe_no_done", bad, 0);
    run_cmd(16'h2000, -1, 16'h0000, 8'h20, 8'h00, "after_reset");

    for (int i = 0; i < 8; i++) begin
      rc = 16'($urandom);
      ri = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 159)) : -1;
      run_cmd(rc, ri, 16'($urandom), rc[15:8], rc[7:0], $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
